// File: rtl/dm_trace_mem.sv
// Data-memory model for the CPU harness: byte-merged stores, fixed-latency reads,
// post-reset clear sweep and a first-word-fall-through trace FIFO of committed stores.
module dm_trace_mem #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned TRACE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic        m_data_rd,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        m_data_rvalid,
  output logic        init_done,
  output logic        addr_err,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_inst_addr,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_wdata,
  output logic [15:0] trace_drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned TW = $clog2(TRACE_DEPTH);

  typedef enum logic {StClear, StRun} state_e;

  state_e        state_q;
  logic [AW-1:0] idx_q;
  logic          init_done_q;
  logic          addr_err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [AW-1:0] widx;
  logic          in_range;
  logic          req;
  logic          wr_en;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic [31:0]   rd_word;
  logic          unused_lsb;

  assign offset     = m_data_addr - BASE_ADDR;
  assign widx       = offset[AW+1:2];
  assign in_range   = (offset[31:AW+2] == '0);
  assign unused_lsb = ^offset[1:0];
  assign req        = m_data_rd | (|m_data_byteen);
  assign wr_en      = (state_q == StRun) & in_range & (|m_data_byteen);
  assign old_word   = mem_q[widx];

  always_comb begin
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (m_data_byteen[k]) merged[8*k +: 8] = m_data_wdata[8*k +: 8];
    end
  end

  // Write-first: a same-cycle store to the read word is visible to the read.
  always_comb begin
    rd_word = '0;
    if (state_q == StRun && in_range) rd_word = wr_en ? merged : old_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StClear;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          idx_q <= idx_q + AW'(1);
          if (idx_q == AW'(DEPTH_WORDS - 1)) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end
        end
        StRun: state_q <= StRun;
        default: state_q <= StClear;
      endcase
      if (req && !in_range) addr_err_q <= 1'b1;
    end
  end

  // Storage has no reset; the sweep provides the cleared contents.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[idx_q] <= '0;
    end else if (wr_en) begin
      mem_q[widx] <= merged;
    end
  end

  logic [RD_LAT-1:0] rv_q;
  logic [31:0]       rdat_q [RD_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv_q <= '0;
      for (int i = 0; i < RD_LAT; i++) rdat_q[i] <= '0;
    end else begin
      rv_q[0]   <= m_data_rd;
      rdat_q[0] <= m_data_rd ? rd_word : 32'h0;
      for (int i = 1; i < RD_LAT; i++) begin
        rv_q[i]   <= rv_q[i-1];
        rdat_q[i] <= rdat_q[i-1];
      end
    end
  end

  assign m_data_rvalid = rv_q[RD_LAT-1];
  assign m_data_rdata  = rdat_q[RD_LAT-1];
  assign init_done     = init_done_q;
  assign addr_err      = addr_err_q;

  logic [TW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]  drop_q, drop_d;
  logic [95:0]  fifo_q [TRACE_DEPTH];
  logic [95:0]  head;
  logic         empty, full, pop, push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[TW] != rd_ptr_q[TW]) && (wr_ptr_q[TW-1:0] == rd_ptr_q[TW-1:0]);
  assign pop     = !empty && trace_ready;
  assign push_ok = wr_en && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    if (pop)     rd_ptr_d = rd_ptr_q + (TW+1)'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + (TW+1)'(1);
    if (wr_en && full && !pop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q[TW-1:0]] <= {m_inst_addr, m_data_addr[31:2], 2'b00, merged};
    end
  end

  // Head fields are forced to zero when empty so stale slots never leak out.
  assign head            = fifo_q[rd_ptr_q[TW-1:0]];
  assign trace_valid     = !empty;
  assign trace_inst_addr = empty ? 32'h0 : head[95:64];
  assign trace_addr      = empty ? 32'h0 : head[63:32];
  assign trace_wdata     = empty ? 32'h0 : head[31:0];
  assign trace_drop_cnt  = drop_q;

endmodule

// File: doc/dm_trace_mem.md
Name: dm_trace_mem

Overview:
- Synthesizable, parametrised data-memory model for the pipelined CPU harness.
- Merges byte-enable writes into 32-bit words and serves reads with a configurable read latency.
- Clears itself after reset with a sweep state machine.
- Logs every committed store (PC, aligned address, merged word) into a trace FIFO, drained by the bench through a valid/ready handshake.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words (power of two, 16..65536)
BASE_ADDR, 32'h0000_0000, byte address of word 0
RD_LAT, 1, read latency in cycles (1..4)
TRACE_DEPTH, 8, trace FIFO entries (power of two, 2..64)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
m_data_addr  in  32  byte address for read/write
m_data_rd  in  1  read request
m_data_wdata  in  32  store data, already lane-aligned
m_data_byteen  in  4  byte-lane write enables; nonzero means write
m_inst_addr  in  32  PC of the storing instruction
m_data_rdata  out  32  read data
m_data_rvalid  out  1  m_data_rdata valid this cycle
init_done  out  1  clear sweep complete
addr_err  out  1  sticky out-of-range flag
trace_valid  out  1  trace head valid
trace_ready  in  1  bench accepts trace head
trace_inst_addr  out  32  head PC
trace_addr  out  32  head word-aligned byte address
trace_wdata  out  32  head merged word
trace_drop_cnt  out  16  stores lost to FIFO full, saturating

Behaviour:
- Reset (async, any time):
  - state=CLEAR, sweep index=0, pipeline flushed, FIFO emptied, trace_drop_cnt=0, addr_err=0.
  - All outputs 0.
  - Reset mid-sweep or mid-traffic restarts the sweep from index 0.
- States:
  - CLEAR: writes 0 to word[idx] each cycle, idx++. When idx==DEPTH_WORDS-1 is written, next state is RUN and init_done=1 from the following cycle. The sweep takes exactly DEPTH_WORDS cycles.
  - While CLEAR: stores are dropped and not traced; reads still pipeline and return 0.
  - RUN: stays in RUN until reset.
- Addressing:
  - word index = (m_data_addr - BASE_ADDR) >> 2; low two address bits ignored.
  - trace_addr = m_data_addr & ~3.
  - Index >= DEPTH_WORDS: write ignored and not traced, read returns 0, addr_err set (sticky until reset). Applies only to cycles with a read or write request.
- Write (RUN, in range, byteen!=0):
  - merged word = old word with lanes k replaced by wdata[8k+7:8k] where byteen[k]=1.
  - Committed at the rising edge.
- Read:
  - Request sampled at edge T; m_data_rvalid=1 and m_data_rdata valid during cycle T+RD_LAT.
  - Back-to-back requests return one per cycle, in order.
  - When no data is valid, m_data_rdata=0.
  - A read and a write to the same word in the same cycle return the merged (new) word (write-first).
- Trace FIFO:
  - First-word-fall-through. Push on every committed write. Pop when trace_valid & trace_ready.
  - Full with no pop in the same cycle: entry dropped, trace_drop_cnt++, saturating at 16'hFFFF.
  - Full with a pop in the same cycle: push accepted, occupancy unchanged.
  - Empty with a push: entry visible at the head the next cycle.
  - Head outputs hold stable while trace_valid=1 and trace_ready=0.

Test Plan:
- Reset sequence: reset=1 for 5 cycles, then 0 -> init_done rises exactly DEPTH_WORDS cycles later (4096 for defaults); a read of addr 0x10 issued mid-sweep returns 0 with rvalid one cycle later.
- Byte merge: sw 0x11223344 to 0x20, then byteen=4'b0010 with wdata=0x0000AB00 -> read 0x20 returns 0x1122AB44; trace head is {PC, 0x20, 0x1122AB44}.
- Latency: RD_LAT=3, reads to 0x0/0x4/0x8 on consecutive cycles -> rvalid high on cycles T+3..T+5 with data in issue order; same-cycle write/read to 0x8 returns the merged word.
- Overflow: TRACE_DEPTH=8, trace_ready=0, 10 stores -> 8 entries retained in order, trace_drop_cnt=2. Then ready=1 plus a store in a full cycle -> pop and push both occur, count stays 2.
- Out of range: DEPTH_WORDS=16, store to 0x40 -> memory unchanged, no trace entry, addr_err=1 persists until reset.
- Reset mid-run: assert reset with 3 queued trace entries and reads in flight -> trace_valid, rvalid and trace_drop_cnt drop to 0 asynchronously; memory re-clears to 0 after the sweep.
